reorder_buffer: RTL

In-order commit unit and the receiving end of the Result bus. Dispatch allocates a commit_id per instruction. Execution units (ALU/FPU/branch/memory/UART) send Result messages out of order through the Message receiver handshake. The block retires the oldest completed entry each cycle, emitting register writeback (CommitInfo fields) or a misprediction flush to fetch.

---
 rtl/reorder_buffer_pkg.sv | 36 +++
 rtl/reorder_buffer.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/reorder_buffer_pkg.sv
// Shared types for the reorder buffer: the Result message received from the
// execution units, the CommitInfo writeback record and the per-entry layout.
package reorder_buffer_pkg;

  localparam int ROB_DEPTH_DEFAULT = 16;

  typedef enum logic {
    KIND_WB     = 1'b0,
    KIND_BRANCH = 1'b1
  } kind_e;

  // Result message: a wb result uses data, a branch result uses miss/new_pc.
  typedef struct packed {
    kind_e       kind;
    logic [7:0]  commit_id;
    logic [31:0] data;
    logic        miss;
    logic [15:0] new_pc;
  } result_t;

  typedef struct packed {
    logic [7:0]  dest_logic;
    logic [31:0] data;
  } commit_info_t;

  typedef struct packed {
    logic        valid;
    logic        done;
    kind_e       kind;
    logic [7:0]  dest_logic;
    logic [31:0] data;
    logic        miss;
    logic [15:0] new_pc;
  } rob_entry_t;

endpackage

// File: rtl/reorder_buffer.sv
// In-order commit unit. Dispatch allocates entries at the tail, execution
// units complete them out of order, and the oldest completed entry retires
// each cycle as a register writeback or a misprediction flush.
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int DEPTH = ROB_DEPTH_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        alloc_en,
  input  logic        alloc_kind,
  input  logic [7:0]  alloc_dest_logic,
  output logic [7:0]  alloc_id,
  output logic        alloc_reject,
  input  logic        result_en,
  input  result_t     result_msg,
  output logic        result_reject,
  output logic        commit_en,
  output logic [7:0]  commit_dest_logic,
  output logic [31:0] commit_data,
  output logic        flush,
  output logic [15:0] flush_pc,
  output logic        err
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [IDX_W:0] FULL_COUNT = (IDX_W+1)'(DEPTH);

  rob_entry_t       entries [DEPTH];
  logic [IDX_W-1:0] head;
  logic [IDX_W-1:0] tail;
  logic [IDX_W:0]   count;
  logic [IDX_W:0]   count_next;
  commit_info_t     commit_q;

  rob_entry_t       head_entry;
  rob_entry_t       result_entry;
  logic [IDX_W-1:0] result_idx;
  logic             retire_now;
  logic             retire_flush_now;
  logic             retire_wb_now;
  logic             alloc_accept;
  logic             result_write;
  logic             result_error;
  logic             result_id_unused;

  // Retire decisions look only at registered entry state.
  assign head_entry       = entries[head];
  assign retire_now       = head_entry.valid && head_entry.done;
  assign retire_flush_now = retire_now && (head_entry.kind == KIND_BRANCH) && head_entry.miss;
  assign retire_wb_now    = retire_now && (head_entry.kind == KIND_WB);

  // A retire in the same cycle does not free a slot; a flush blocks dispatch.
  assign alloc_reject = (count == FULL_COUNT) || retire_flush_now;
  assign alloc_accept = alloc_en && !alloc_reject;
  assign alloc_id     = 8'(tail);

  // Only the low index bits of commit_id select an entry.
  assign result_idx       = result_msg.commit_id[IDX_W-1:0];
  assign result_id_unused = ^result_msg.commit_id;
  assign result_entry     = entries[result_idx];
  assign result_write     = result_en && result_entry.valid && !retire_flush_now;
  assign result_error     = result_write &&
                            (result_entry.done || (result_msg.kind != result_entry.kind));
  assign result_reject    = 1'b0;

  assign commit_dest_logic = commit_q.dest_logic;
  assign commit_data       = commit_q.data;

  // Occupancy after this cycle's alloc/retire pair (flush handled separately).
  always_comb begin
    // NOTE: defaulting every always_comb output first keeps all paths assigned, so no latch is inferred.
    count_next = count;
    if (alloc_accept && !retire_now) begin
      count_next = count + 1'b1;
    end else if (!alloc_accept && retire_now) begin
      count_next = count - 1'b1;
    end
  end

  // Entry array: result completion, retire invalidation, then tail allocation.
  always_ff @(posedge clk) begin
    if (reset || retire_flush_now) begin
      // NOTE: only valid/done need a reset; payload fields are never read while valid is low.
      for (int i = 0; i < DEPTH; i++) begin
        entries[i].valid <= 1'b0;
        entries[i].done  <= 1'b0;
      end
    end else begin
      if (result_write) begin
        entries[result_idx].done   <= 1'b1;
        entries[result_idx].data   <= result_msg.data;
        entries[result_idx].miss   <= result_msg.miss;
        entries[result_idx].new_pc <= result_msg.new_pc;
      end
      if (retire_now) begin
        entries[head].valid <= 1'b0;
        entries[head].done  <= 1'b0;
      end
      if (alloc_accept) begin
        entries[tail].valid      <= 1'b1;
        entries[tail].done       <= 1'b0;
        entries[tail].kind       <= kind_e'(alloc_kind);
        entries[tail].dest_logic <= alloc_dest_logic;
      end
    end
  end

  // Pointers, occupancy, sticky error and the registered commit/flush outputs.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      err       <= 1'b0;
      commit_en <= 1'b0;
      commit_q  <= '0;
      flush     <= 1'b0;
      flush_pc  <= '0;
    end else if (retire_flush_now) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      commit_en <= 1'b0;
      flush     <= 1'b1;
      flush_pc  <= head_entry.new_pc;
    end else begin
      if (alloc_accept) tail <= tail + 1'b1;
      if (retire_now)   head <= head + 1'b1;
      count     <= count_next;
      flush     <= 1'b0;
      commit_en <= retire_wb_now;
      if (retire_wb_now) begin
        commit_q <= '{dest_logic: head_entry.dest_logic, data: head_entry.data};
      end
      if (result_error) err <= 1'b1;
    end
  end

endmodule
